// File: rtl/fwrisc_trace_pkg.sv
// rtl/fwrisc_trace_pkg.sv - trace record type, capture mode enum and record width
package fwrisc_trace_pkg;

  typedef enum logic [1:0] {
    TRACE_MODE_OFF  = 2'b00,
    TRACE_MODE_ALL  = 2'b01,
    TRACE_MODE_TRAP = 2'b10,
    TRACE_MODE_MEM  = 2'b11
  } fwrisc_trace_mode_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  rd_waddr;
    logic [31:0] rd_wdata;
    logic        rd_write;
    logic        trap;
    logic        tret;
    logic        mem_valid;
    logic [31:0] maddr;
    logic [31:0] mdata;
    logic [3:0]  mstrb;
    logic        mwrite;
    logic        lost;
  } fwrisc_trace_rec_t;

  localparam int TRACE_REC_W = $bits(fwrisc_trace_rec_t);

endpackage

// File: rtl/fwrisc_trace_fifo.sv
// rtl/fwrisc_trace_fifo.sv - flop-array FIFO with drop or overwrite-oldest full policy
module fwrisc_trace_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int OVERWRITE = 0
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_drop,
  output logic                     o_written
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;

  logic w_full;
  logic w_pop;
  logic w_evict;

  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_pop     = i_pop && (r_count != '0);
  // A simultaneous pop always makes room, so only an unpaired push on full loses data.
  assign o_drop    = i_push && w_full && !w_pop;
  assign o_written = i_push && (!o_drop || (OVERWRITE != 0));
  assign w_evict   = o_drop && (OVERWRITE != 0);

  assign o_valid = (r_count != '0);
  assign o_rdata = r_mem[r_rptr];
  assign o_level = r_count;

  // Record storage; contents are meaningless until written, so no reset.
  always_ff @(posedge i_clock) begin
    if (o_written) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers wrap naturally at the power-of-two depth; the count tells full from empty.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (o_written) r_wptr <= r_wptr + 1'b1;
      if (w_pop || w_evict) r_rptr <= r_rptr + 1'b1;
      if (i_push && !w_full && !w_pop) r_count <= r_count + 1'b1;
      else if (w_pop && !i_push)       r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/fwrisc_trace_buffer.sv
// rtl/fwrisc_trace_buffer.sv - filters retire/memory events into trace records and queues them
module fwrisc_trace_buffer
  import fwrisc_trace_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int OVERWRITE = 0,
  parameter int CNT_W     = 16
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [1:0]              i_mode,
  input  logic [31:0]             i_pc,
  input  logic [31:0]             i_instr,
  input  logic                    i_ivalid,
  input  logic                    i_trap,
  input  logic                    i_tret,
  input  logic [5:0]              i_rd_waddr,
  input  logic [31:0]             i_rd_wdata,
  input  logic                    i_rd_write,
  input  logic [31:0]             i_maddr,
  input  logic [31:0]             i_mdata,
  input  logic [3:0]              i_mstrb,
  input  logic                    i_mwrite,
  input  logic                    i_mvalid,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output fwrisc_trace_rec_t       o_out_rec,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic [CNT_W-1:0]        o_drop_cnt
);

  logic                   r_pend;
  logic [31:0]            r_pmaddr;
  logic [31:0]            r_pmdata;
  logic [3:0]             r_pmstrb;
  logic                   r_pmwrite;
  logic                   r_lost_pend;
  logic [CNT_W-1:0]       r_drop_cnt;

  fwrisc_trace_rec_t      w_rec;
  logic                   w_qual;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_drop;
  logic                   w_written;
  logic [TRACE_REC_W-1:0] w_rdata;

  // Assemble the candidate record; a same-cycle access wins over a pending one.
  always_comb begin
    w_rec           = '0;
    w_rec.pc        = i_pc;
    w_rec.instr     = i_instr;
    w_rec.rd_waddr  = i_rd_waddr;
    w_rec.rd_wdata  = i_rd_wdata;
    w_rec.rd_write  = i_rd_write;
    w_rec.trap      = i_trap;
    w_rec.tret      = i_tret;
    w_rec.lost      = r_lost_pend;
    if (i_mvalid) begin
      w_rec.mem_valid = 1'b1;
      w_rec.maddr     = i_maddr;
      w_rec.mdata     = i_mdata;
      w_rec.mstrb     = i_mstrb;
      w_rec.mwrite    = i_mwrite;
    end else if (r_pend) begin
      w_rec.mem_valid = 1'b1;
      w_rec.maddr     = r_pmaddr;
      w_rec.mdata     = r_pmdata;
      w_rec.mstrb     = r_pmstrb;
      w_rec.mwrite    = r_pmwrite;
    end
  end

  // Decide whether the retiring instruction is captured under the current mode.
  always_comb begin
    w_qual = 1'b0;
    case (fwrisc_trace_mode_e'(i_mode))
      TRACE_MODE_ALL:  w_qual = 1'b1;
      TRACE_MODE_TRAP: w_qual = i_trap || i_tret;
      TRACE_MODE_MEM:  w_qual = w_rec.mem_valid;
      default:         w_qual = 1'b0;
    endcase
  end

  assign w_push      = i_ivalid && w_qual;
  assign w_pop       = o_out_valid && i_out_ready;
  assign o_out_rec   = fwrisc_trace_rec_t'(w_rdata);
  assign o_drop_cnt  = r_drop_cnt;

  fwrisc_trace_fifo #(
    .WIDTH     (TRACE_REC_W),
    .DEPTH     (DEPTH),
    .OVERWRITE (OVERWRITE)
  ) u_fifo (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_push    (w_push),
    .i_wdata   (w_rec),
    .i_pop     (w_pop),
    .o_valid   (o_out_valid),
    .o_rdata   (w_rdata),
    .o_level   (o_level),
    .o_drop    (w_drop),
    .o_written (w_written)
  );

  // Hold the last memory access not yet claimed by a retiring instruction.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_pend    <= 1'b0;
      r_pmaddr  <= '0;
      r_pmdata  <= '0;
      r_pmstrb  <= '0;
      r_pmwrite <= 1'b0;
    end else if (i_ivalid) begin
      r_pend    <= 1'b0;
    end else if (i_mvalid) begin
      r_pend    <= 1'b1;
      r_pmaddr  <= i_maddr;
      r_pmdata  <= i_mdata;
      r_pmstrb  <= i_mstrb;
      r_pmwrite <= i_mwrite;
    end
  end

  // Count losses and flag the next stored record; an overwrite both stores and loses.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_lost_pend <= 1'b0;
      r_drop_cnt  <= '0;
    end else if (w_drop) begin
      r_lost_pend <= 1'b1;
      if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
    end else if (w_written) begin
      r_lost_pend <= 1'b0;
    end
  end

endmodule

// File: doc/fwrisc_trace_buffer.md
# fwrisc_trace_buffer

Parametrised trace capture buffer for the fwrisc core. It takes the same retire-stage and memory-access signals that feed the debug tracer. It filters them by a run-time mode and packs each retired instruction, plus any preceding memory access, into one record. Records sit in a FIFO of configurable depth and drain through a valid/ready stream to a consumer such as an on-chip trace port or a DMA. Overflow is handled by a selectable policy and reported by counters.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- OVERWRITE, 0, full policy: 0 drops the new record, 1 overwrites the oldest.
- CNT_W, 16, width of the saturating drop counter.

Ports (direction, width, meaning):
- clock, in, 1, single clock.
- reset, in, 1, asynchronous, active-low reset.
- mode, in, 2, capture mode: 00 off, 01 all retired, 10 trap/tret only, 11 memory-access only.
- pc, in, 32, retiring PC.
- instr, in, 32, retiring instruction.
- ivalid, in, 1, an instruction retires this cycle.
- trap, in, 1, retiring instruction trapped.
- tret, in, 1, retiring instruction is a trap return.
- rd_waddr, in, 6, destination register.
- rd_wdata, in, 32, write-back data.
- rd_write, in, 1, write-back valid.
- maddr, in, 32, memory address.
- mdata, in, 32, memory data.
- mstrb, in, 4, byte strobes.
- mwrite, in, 1, 1 = store.
- mvalid, in, 1, memory access completes this cycle.
- out_valid, out, 1, a record is available.
- out_ready, in, 1, consumer accepts the record.
- out_rec, out, fwrisc_trace_rec_t, head record.
- level, out, $clog2(DEPTH)+1, current occupancy.
- drop_cnt, out, CNT_W, records lost to the full condition; saturates.

## Operation
- Record fields: pc, instr, rd_waddr, rd_wdata, rd_write, trap, tret, mem_valid, maddr, mdata, mstrb, mwrite, lost.
- Pending memory register:
  - mvalid without ivalid latches maddr, mdata, mstrb and mwrite into the pending register and sets pend=1.
  - If a second mvalid arrives before the next ivalid, it overwrites the pending register.
- Record assembly on ivalid:
  - If mvalid is also high this cycle, the live memory fields are used.
  - Otherwise, if pend=1, the pending fields are used.
  - Otherwise mem_valid=0 and the memory fields are 0.
  - Every ivalid clears pend, even when the record is filtered out.
- Filter: a push happens only when ivalid=1 and the mode qualifies.
  - 01: every retired instruction.
  - 10: trap or tret is high.
  - 11: the record's mem_valid=1.
  - 00: no push; pend still tracks memory accesses.
- Pop happens when out_valid and out_ready are both high.
- Push and pop in the same cycle:
  - Always both accepted, even when full; level is unchanged.
- Push while full with no pop, OVERWRITE=0:
  - The record is discarded.
  - drop_cnt increments, saturating at all-ones.
  - Sticky lost_pend is set.
- Push while full with no pop, OVERWRITE=1:
  - The oldest entry is discarded and the read pointer advances.
  - drop_cnt increments and lost_pend is set.
- lost flag: the next record actually written carries lost=lost_pend, and writing it clears lost_pend.
- Pointers wrap modulo DEPTH; a separate occupancy count distinguishes full from empty.
- Changing mode mid-stream affects only later ivalid cycles; stored records are untouched.

## Timing
- Reset values: out_valid=0, level=0, drop_cnt=0, pend=0, lost_pend=0, pointers=0. out_rec reads storage, which is not reset.
- Capture latency: ivalid at cycle N gives out_valid=1 at N+1 when the FIFO was empty.
- out_rec and out_valid are driven from registered state only; out_ready has no combinational path to them.
- out_rec must stay stable while out_valid=1 and out_ready=0. Under OVERWRITE=1, an overwrite when full replaces the head; this is the one allowed exception.
- level and drop_cnt update on the clock edge after the push or pop.
- Reset asserted mid-stream clears the FIFO, counters and pending state immediately. Records are lost without being counted.

## Structure
- Package fwrisc_trace_pkg holds:
  - fwrisc_trace_rec_t, a packed struct of the record fields.
  - fwrisc_trace_mode_e, the 2-bit mode enum.
  - The constant TRACE_REC_W.
- Sub-module fwrisc_trace_fifo: a generic flop-array FIFO parametrised by width, DEPTH and OVERWRITE, with push/pop, occupancy and a drop pulse.
- The top level holds the pending-memory register, the filter, lost_pend and drop_cnt.

## Test plan
- Mode 01, DEPTH=4, three ivalid cycles (pc 0x100, 0x104, 0x108), out_ready=1: three records in order, each out_valid the cycle after its ivalid, level returns to 0.
- mvalid store (maddr 0x2000, mdata 0xDEAD, mstrb 0xF) two cycles before ivalid at pc 0x200: that record has mem_valid=1 with those fields. The next record has mem_valid=0.
- Mode 10, ivalid ×5 with trap=1 only on the 3rd: exactly one record, trap=1.
- OVERWRITE=0, DEPTH=4, out_ready=0, 6 pushes: level=4, drop_cnt=2. After draining, the next pushed record has lost=1 and the one after it has lost=0.
- OVERWRITE=1, same stimulus: drained records are pushes 3–6, and drop_cnt=2.
- FIFO full with push and pop in the same cycle: level stays 4 and drop_cnt is unchanged. Then assert reset mid-drain: out_valid=0 and level=0 asynchronously.
